pwm_audio_out: RTL and testbench



---
 rtl/pwm_audio_pkg.sv | 24 ++
 rtl/pwm_audio_out_sample_fifo.sv | 54 +++++
 rtl/pwm_audio_out.sv | 91 +++++++++
 tb/tb_pwm_audio_out.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_audio_pkg.sv
// Shared types, constants and the duty scaling helper for the PWM audio output path.
package pwm_audio_pkg;

    localparam int SAMPLE_W_DEFAULT   = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef logic [SAMPLE_W_DEFAULT-1:0] sample_t;

    localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;

    // duty = (sample * period) >> sample_w. The product is formed at 64 bits so it
    // holds the full 32+sample_w result; the full-scale sample therefore stays below period.
    function automatic logic [31:0] scale_duty(
        input logic [31:0] sample,
        input logic [31:0] period,
        input int unsigned sample_w
    );
        logic [63:0] product;
        product = {32'd0, sample} * {32'd0, period};
        product = product >> sample_w;
        return product[31:0];
    endfunction

endpackage

// File: rtl/pwm_audio_out_sample_fifo.sv
// Synchronous sample FIFO: a push is ignored when full, a pop is ignored when empty.
module sample_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: queues samples, loads a period-scaled duty at each counter wrap,
// and drives a registered PWM bit with underflow reporting.
module pwm_audio_out
    import pwm_audio_pkg::*;
#(
    parameter  int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [31:0]         count_in,
    input  logic [31:0]         period_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid_in,
    output logic                sample_ready_out,
    output logic                pwm_out,
    output logic                frame_out,
    output logic                underflow_out,
    output logic [15:0]         underflow_cnt_out,
    output logic [LEVEL_W-1:0]  level_out
);

    logic                wrap;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] head;
    logic [31:0]         duty_q;
    logic                pwm_q;
    logic                frame_q;
    logic                underflow_q;
    logic [15:0]         underflow_cnt_q;

    // Handshake: a sample transfers on any rising edge where sample_valid_in and
    // sample_ready_out are both high; ready is !full and does not look at valid.
    assign sample_ready_out = !fifo_full;

    assign wrap = (period_in != 32'd0) && (count_in == period_in - 32'd1);

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (sample_valid_in),
        .push_data (sample_in),
        .pop       (wrap),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_out)
    );

    // Duty loads on the wrap edge so count 0 of the new frame already sees it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            duty_q <= 32'd0;
        end else if (wrap && !fifo_empty) begin
            duty_q <= scale_duty(32'(head), period_in, SAMPLE_W);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_q         <= 1'b0;
            underflow_q     <= 1'b0;
            underflow_cnt_q <= 16'd0;
        end else begin
            frame_q     <= wrap;
            underflow_q <= wrap && fifo_empty;
            if (wrap && fifo_empty && (underflow_cnt_q != UNDERFLOW_MAX)) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (period_in != 32'd0) && (count_in < duty_q);
        end
    end

    assign pwm_out           = pwm_q;
    assign frame_out         = frame_q;
    assign underflow_out     = underflow_q;
    assign underflow_cnt_out = underflow_cnt_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: queue-based reference model checked every cycle,
// a table of scaling vectors, and directed sequences for FIFO-full, reset and zero-period cases.
module tb_pwm_audio_out;

    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        int unsigned sample;
        int unsigned period;
        int unsigned exp_duty;
    } vec_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [31:0]   count_in = 32'd0;
    logic [31:0]   period_in = 32'd0;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          sample_ready_out;
    logic          pwm_out;
    logic          frame_out;
    logic          underflow_out;
    logic [15:0]   underflow_cnt_out;
    logic [LW-1:0] level_out;

    // Reference model state
    logic [SW-1:0] exp_q[$];
    longint        m_duty = 0;
    int            m_ucnt = 0;
    bit            m_pwm, m_frame, m_uf;

    int checks = 0;
    int errors = 0;

    vec_t vecs[9];

    pwm_audio_out #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .count_in          (count_in),
        .period_in         (period_in),
        .sample_in         (sample_in),
        .sample_valid_in   (sample_valid_in),
        .sample_ready_out  (sample_ready_out),
        .pwm_out           (pwm_out),
        .frame_out         (frame_out),
        .underflow_out     (underflow_out),
        .underflow_cnt_out (underflow_cnt_out),
        .level_out         (level_out)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict from the rules, take the edge, compare, advance the period counter.
    task automatic step(output bit accepted);
        bit wrap;
        wrap     = (period_in != 0) && (count_in == period_in - 1);
        m_pwm    = (period_in != 0) && (longint'(count_in) < m_duty);
        m_frame  = wrap;
        m_uf     = wrap && (exp_q.size() == 0);
        accepted = sample_valid_in && (exp_q.size() < DEPTH);
        if (wrap) begin
            if (exp_q.size() != 0)
                m_duty = (longint'(exp_q.pop_front()) * longint'(period_in)) >> SW;
            else if (m_ucnt < 65535)
                m_ucnt++;
        end
        if (accepted) exp_q.push_back(sample_in);

        @(posedge clk_in);
        #1;
        check("pwm",       longint'(pwm_out),           longint'(m_pwm));
        check("frame",     longint'(frame_out),         longint'(m_frame));
        check("underflow", longint'(underflow_out),     longint'(m_uf));
        check("uf_cnt",    longint'(underflow_cnt_out), longint'(m_ucnt));
        check("level",     longint'(level_out),         longint'(exp_q.size()));
        check("ready",     longint'(sample_ready_out),  longint'(exp_q.size() < DEPTH));

        if (period_in == 0 || wrap) count_in = 32'd0;
        else                        count_in = count_in + 32'd1;
    endtask

    task automatic tick();
        bit acc;
        step(acc);
    endtask

    task automatic push_one(input logic [SW-1:0] s);
        bit acc;
        sample_valid_in = 1'b1;
        sample_in       = s;
        step(acc);
        sample_valid_in = 1'b0;
        check("push_accept", longint'(acc), 1);
    endtask

    // Asserts reset between edges and checks outputs clear without waiting for a clock.
    task automatic do_reset();
        rst_in = 1'b1;
        #2;
        check("rst_pwm",    longint'(pwm_out),           0);
        check("rst_frame",  longint'(frame_out),         0);
        check("rst_uf",     longint'(underflow_out),     0);
        check("rst_uf_cnt", longint'(underflow_cnt_out), 0);
        check("rst_level",  longint'(level_out),         0);
        check("rst_ready",  longint'(sample_ready_out),  1);
        exp_q.delete();
        m_duty          = 0;
        m_ucnt          = 0;
        count_in        = 32'd0;
        sample_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic wait_frame(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_out && n < bound);
        check("frame_seen", longint'(frame_out), 1);
    endtask

    initial begin
        int hi;
        int frames;
        int acc_total;
        bit acc;

        vecs[0] = '{128, 100, 50};
        vecs[1] = '{0, 100, 0};
        vecs[2] = '{255, 100, 99};
        vecs[3] = '{64, 100, 25};
        vecs[4] = '{255, 10, 9};
        vecs[5] = '{1, 256, 1};
        vecs[6] = '{200, 7, 5};
        vecs[7] = '{255, 1, 0};
        vecs[8] = '{100, 1000, 390};

        #1;
        do_reset();

        // Scaling table: load one sample, measure high time, then underflow and confirm duty holds.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            period_in = 32'd0;
            push_one(SW'(vecs[i].sample));
            period_in = vecs[i].period;
            count_in  = 32'd0;
            wait_frame(int'(vecs[i].period) + 4);
            hi = 0;
            for (int c = 0; c < int'(vecs[i].period); c++) begin
                tick();
                hi += int'(pwm_out);
            end
            check($sformatf("duty_v%0d", i), longint'(hi), longint'(vecs[i].exp_duty));
            check($sformatf("uf_pulse_v%0d", i), longint'(underflow_out), 1);
            check($sformatf("uf_cnt_v%0d", i), longint'(underflow_cnt_out), 1);
            hi = 0;
            for (int c = 0; c < int'(vecs[i].period); c++) begin
                tick();
                hi += int'(pwm_out);
            end
            check($sformatf("duty_hold_v%0d", i), longint'(hi), longint'(vecs[i].exp_duty));
        end

        // Back-to-back samples 0 then 255 at period 100.
        do_reset();
        period_in = 32'd0;
        push_one(8'd0);
        push_one(8'd255);
        period_in = 32'd100;
        count_in  = 32'd0;
        wait_frame(110);
        hi = 0;
        for (int c = 0; c < 100; c++) begin tick(); hi += int'(pwm_out); end
        check("seq_frame1_zero", longint'(hi), 0);
        check("seq_frame2_load", longint'(frame_out), 1);
        hi = 0;
        for (int c = 0; c < 100; c++) begin tick(); hi += int'(pwm_out); end
        check("seq_frame2_99", longint'(hi), 99);

        // Valid held high: fill to full, then exactly one accept per freed slot.
        do_reset();
        period_in       = 32'd1000;
        count_in        = 32'd0;
        sample_valid_in = 1'b1;
        acc_total       = 0;
        for (int k = 0; k < 4; k++) begin
            sample_in = SW'($urandom_range(0, 255));
            step(acc);
            acc_total += int'(acc);
        end
        check("full_accepts", longint'(acc_total), 4);
        check("full_ready",   longint'(sample_ready_out), 0);
        check("full_level",   longint'(level_out), 4);
        acc_total = 0;
        hi = 0;
        do begin
            sample_in = SW'($urandom_range(0, 255));
            step(acc);
            acc_total += int'(acc);
            hi++;
        end while (!frame_out && hi < 1100);
        check("full_wrap_frame", longint'(frame_out), 1);
        check("full_wrap_level", longint'(level_out), 3);
        check("full_no_accept",  longint'(acc_total), 0);
        step(acc);
        check("refill_accept", longint'(acc), 1);
        check("refill_level",  longint'(level_out), 4);
        for (int k = 0; k < 5; k++) begin
            step(acc);
            acc_total += int'(acc);
        end
        check("refill_once", longint'(acc_total), 0);
        sample_valid_in = 1'b0;

        // Reset mid-frame with three samples queued and the output high.
        do_reset();
        period_in = 32'd0;
        for (int k = 0; k < 4; k++) push_one(8'd200);
        period_in = 32'd1000;
        count_in  = 32'd0;
        wait_frame(1010);
        for (int k = 0; k < 10; k++) tick();
        check("pre_rst_pwm",   longint'(pwm_out), 1);
        check("pre_rst_level", longint'(level_out), 3);
        do_reset();

        // Zero period: no frames, nothing consumed, output low.
        period_in = 32'd0;
        for (int k = 0; k < 3; k++) push_one(SW'($urandom_range(1, 255)));
        m_duty = m_duty;
        frames = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            frames += int'(frame_out);
        end
        check("p0_frames", longint'(frames), 0);
        check("p0_level",  longint'(level_out), 3);
        check("p0_pwm",    longint'(pwm_out), 0);

        // Random traffic with period changes at frame starts.
        do_reset();
        period_in = 32'($urandom_range(1, 40));
        count_in  = 32'd0;
        for (int chunk = 0; chunk < 8; chunk++) begin
            int rate;
            rate = $urandom_range(5, 95);
            for (int k = 0; k < 500; k++) begin
                sample_valid_in = ($urandom_range(0, 99) < rate);
                sample_in       = SW'($urandom_range(0, 255));
                tick();
                if (count_in == 0 && $urandom_range(0, 7) == 0)
                    period_in = 32'($urandom_range(0, 40));
            end
        end
        sample_valid_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
